// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master slice.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // Upper address half that maps onto the completer window.
  localparam logic [15:0] APB_BASE = 16'h1000;

  localparam int unsigned DEF_NUM_SLV = 4;
  localparam int unsigned DEF_TIMEOUT = 256;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational completer decode: 4 KiB slots inside the APB_BASE window.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLV = DEF_NUM_SLV
) (
  input  logic [31:0]        addr,
  output logic [NUM_SLV-1:0] sel,
  output logic               miss
);

  logic        base_hit;
  logic [11:0] unused_offset;

  assign base_hit      = (addr[31:16] == APB_BASE);
  assign unused_offset = addr[11:0];

  // One-hot slot select from addr[15:12]; anything unmapped is a miss.
  always_comb begin
    sel  = '0;
    miss = 1'b1;
    for (int unsigned k = 0; k < NUM_SLV; k++) begin
      if (base_hit && (32'(addr[15:12]) == k)) begin
        sel[k] = 1'b1;
        miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester with address decode, wait-state
// timeout and one-cycle host completion pulse.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLV = DEF_NUM_SLV,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    transfer,
  input  logic                    write,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    ready,
  output logic                    err,
  output logic                    busy,
  output logic [31:0]             PADDR,
  output logic [31:0]             PWDATA,
  output logic                    PWRITE,
  output logic                    PENABLE,
  output logic [NUM_SLV-1:0]      PSEL,
  input  logic [NUM_SLV-1:0][31:0] PRDATA,
  input  logic [NUM_SLV-1:0]      PREADY
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  apb_state_t          state;
  logic [CW-1:0]       wait_cnt;
  logic [NUM_SLV-1:0]  dec_sel;
  logic                dec_miss;
  logic                slot_ready;
  logic [31:0]         slot_rdata;

  apb_addr_decoder #(
    .NUM_SLV (NUM_SLV)
  ) u_dec (
    .addr (addr),
    .sel  (dec_sel),
    .miss (dec_miss)
  );

  // Only the selected completer's PREADY counts.
  assign slot_ready = |(PREADY & PSEL);
  assign busy       = (state != IDLE);

  // Read-data mux steered by the registered select.
  always_comb begin
    slot_rdata = '0;
    for (int unsigned k = 0; k < NUM_SLV; k++) begin
      if (PSEL[k]) begin
        slot_rdata = PRDATA[k];
      end
    end
  end

  // Transfer sequencer: IDLE -> SETUP -> ACCESS -> IDLE, outputs registered.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state    <= IDLE;
      PSEL     <= '0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      rdata    <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (transfer) begin
            PADDR  <= addr;
            PWDATA <= wdata;
            PWRITE <= write;
            if (dec_miss) begin
              // Unmapped: complete immediately without touching the bus.
              ready <= 1'b1;
              err   <= 1'b1;
              rdata <= '0;
            end else begin
              PSEL  <= dec_sel;
              state <= SETUP;
            end
          end
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (slot_ready) begin
            if (!PWRITE) begin
              rdata <= slot_rdata;
            end
            PSEL    <= '0;
            PENABLE <= 1'b0;
            ready   <= 1'b1;
            state   <= IDLE;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            PSEL    <= '0;
            PENABLE <= 1'b0;
            ready   <= 1'b1;
            err     <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master with behavioural completers on 4 slots.
module tb_apb_master;

  logic              PCLK;
  logic              PRESET;
  logic              transfer;
  logic              write;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic              err;
  logic              busy;
  logic [31:0]       PADDR;
  logic [31:0]       PWDATA;
  logic              PWRITE;
  logic              PENABLE;
  logic [3:0]        PSEL;
  logic [3:0][31:0]  PRDATA;
  logic [3:0]        PREADY;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          issue;
    logic [3:0]  psel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Completer behaviour: wait states per slot (-1 = never ready) and a register.
  int          wait_cfg [4] = '{0, 1, -1, 2};
  int          acc_cnt  [4] = '{0, 0, 0, 0};
  logic [31:0] mem      [4] = '{32'hDEAD_BEEF, 32'h0, 32'h2222_2222, 32'h3333_3333};

  apb_master #(
    .NUM_SLV (4),
    .TIMEOUT (8)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .transfer (transfer),
    .write    (write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .err      (err),
    .busy     (busy),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PWRITE   (PWRITE),
    .PENABLE  (PENABLE),
    .PSEL     (PSEL),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  // Unselected slots drive PREADY high and junk data so they must be ignored.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      PRDATA[k] = PSEL[k] ? mem[k] : (32'hBAD0_0000 | 32'(k));
      if (!PSEL[k]) PREADY[k] = 1'b1;
      else          PREADY[k] = PENABLE && (acc_cnt[k] == wait_cfg[k]);
    end
  end

  always @(posedge PCLK) begin
    for (int k = 0; k < 4; k++) begin
      if (PRESET)                                 acc_cnt[k] <= 0;
      else if (PSEL[k] && PENABLE && !PREADY[k])  acc_cnt[k] <= acc_cnt[k] + 1;
      else                                        acc_cnt[k] <= 0;
      if (!PRESET && PSEL[k] && PENABLE && PREADY[k] && PWRITE) mem[k] <= PWDATA;
    end
  end

  // Monitor: bus protocol each cycle, pop and compare on every ready pulse.
  always @(negedge PCLK) begin
    if (!PRESET) begin
      checks++;
      if (!$onehot0(PSEL) || (PENABLE && PSEL == 4'b0)) begin
        errors++;
        $display("FAIL psel_onehot actual PSEL=%b PENABLE=%b required onehot0 and nonzero with PENABLE", PSEL, PENABLE);
      end
      if (sbq.size() > 0 && PSEL != 4'b0) begin
        checks++;
        if (PSEL !== sbq[0].psel || PADDR !== sbq[0].addr || PWRITE !== sbq[0].wr ||
            (sbq[0].wr && PWDATA !== sbq[0].wdata)) begin
          errors++;
          $display("FAIL bus actual PSEL=%b PADDR=%h PWRITE=%b PWDATA=%h required PSEL=%b PADDR=%h PWRITE=%b PWDATA=%h",
                   PSEL, PADDR, PWRITE, PWDATA, sbq[0].psel, sbq[0].addr, sbq[0].wr, sbq[0].wdata);
        end
      end
      if (ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready actual ready=1 required ready=0");
        end else begin
          exp_t e;
          e = sbq.pop_front();
          checks++;
          if (err !== e.err) begin
            errors++;
            $display("FAIL err addr=%h actual %b required %b", e.addr, err, e.err);
          end
          checks++;
          if (rdata !== e.rdata) begin
            errors++;
            $display("FAIL rdata addr=%h actual %h required %h", e.addr, rdata, e.rdata);
          end
          checks++;
          if (cyc - e.issue != e.lat) begin
            errors++;
            $display("FAIL latency addr=%h actual %0d required %0d", e.addr, cyc - e.issue, e.lat);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp_v);
    end
  endtask

  // Called at a negedge with busy=0; returns at the negedge of the ready cycle.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat,
                       input logic [3:0] psel, input bit hold, input bit noise);
    exp_t e;
    int   n;
    transfer = 1'b1;
    write    = wr;
    addr     = a;
    wdata    = d;
    e.rdata = exp_rd; e.err = exp_err; e.lat = lat; e.issue = cyc;
    e.psel  = psel;   e.addr = a;      e.wdata = d; e.wr = wr;
    sbq.push_back(e);
    @(posedge PCLK);
    #1;
    if (!hold) transfer = 1'b0;
    n = 0;
    @(negedge PCLK);
    while (busy && n < 40) begin
      if (noise) begin
        transfer = ~transfer;
        write    = ~write;
        addr     = 32'h3000_0000;
      end
      @(negedge PCLK);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL busy_timeout addr=%h actual busy=1 required busy=0 within 40 cycles", a);
    end
  endtask

  initial begin
    int n;
    PRESET   = 1'b1;
    transfer = 1'b0;
    write    = 1'b0;
    addr     = '0;
    wdata    = '0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_psel",    32'(PSEL),    32'h0);
    chk("rst_penable", 32'(PENABLE), 32'h0);
    chk("rst_pwrite",  32'(PWRITE),  32'h0);
    chk("rst_paddr",   PADDR,        32'h0);
    chk("rst_pwdata",  PWDATA,       32'h0);
    chk("rst_rdata",   rdata,        32'h0);
    chk("rst_ready",   32'(ready),   32'h0);
    chk("rst_err",     32'(err),     32'h0);
    chk("rst_busy",    32'(busy),    32'h0);
    PRESET = 1'b0;
    @(negedge PCLK);

    //     wr    addr           wdata          exp rdata      err  lat psel   hold noise
    issue(1'b1, 32'h1000_1004, 32'h0000_0005, 32'h0000_0000, 1'b0, 4, 4'b0010, 0, 0);
    issue(1'b0, 32'h1000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 4'b0001, 0, 0);
    issue(1'b0, 32'h2000_0000, 32'h0,         32'h0000_0000, 1'b1, 1, 4'b0000, 0, 0);
    issue(1'b0, 32'h1000_1004, 32'h0,         32'h0000_0005, 1'b0, 4, 4'b0010, 0, 0);
    issue(1'b1, 32'h1000_3010, 32'hA5A5_0003, 32'h0000_0005, 1'b0, 5, 4'b1000, 0, 0);
    issue(1'b0, 32'h1000_3010, 32'h0,         32'hA5A5_0003, 1'b0, 5, 4'b1000, 0, 0);
    issue(1'b0, 32'h1000_2000, 32'h0,         32'hA5A5_0003, 1'b1, 10, 4'b0100, 0, 0);
    issue(1'b0, 32'h1000_4000, 32'h0,         32'h0000_0000, 1'b1, 1, 4'b0000, 0, 0);
    // Back-to-back with transfer held high.
    issue(1'b0, 32'h1000_0000, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 4'b0001, 1, 0);
    issue(1'b1, 32'h1000_1000, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 4, 4'b0010, 0, 0);
    // Host inputs toggling while busy must not disturb the transfer.
    issue(1'b0, 32'h1000_1000, 32'h0,         32'h1234_5678, 1'b0, 4, 4'b0010, 0, 1);
    transfer = 1'b0;
    issue(1'b0, 32'h1001_0000, 32'h0,         32'h0000_0000, 1'b1, 1, 4'b0000, 0, 0);

    // Reset in the middle of an ACCESS phase to the never-ready slot.
    transfer = 1'b1;
    write    = 1'b0;
    addr     = 32'h1000_2000;
    @(posedge PCLK);
    #1;
    transfer = 1'b0;
    n = 0;
    @(negedge PCLK);
    while (!PENABLE && n < 10) begin
      @(negedge PCLK);
      n++;
    end
    chk("mid_in_access", 32'(PENABLE), 32'h1);
    PRESET = 1'b1;
    @(posedge PCLK);
    #1;
    chk("mid_rst_psel",    32'(PSEL),    32'h0);
    chk("mid_rst_penable", 32'(PENABLE), 32'h0);
    chk("mid_rst_busy",    32'(busy),    32'h0);
    chk("mid_rst_ready",   32'(ready),   32'h0);
    @(negedge PCLK);
    PRESET = 1'b0;
    chk("mid_rst_rdata", rdata, 32'h0);
    repeat (4) @(negedge PCLK);

    issue(1'b0, 32'h1000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 4'b0001, 0, 0);

    repeat (3) @(negedge PCLK);
    chk("sb_drained", 32'(sbq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual still running required finish");
    $fatal(1);
  end

endmodule
